// File: rtl/ram_2port_param.sv
`default_nettype none
// ============================================================================
// Module      : ram_2port_param
// Description : Parametrised simple dual-port RAM (one write port, one read
//               port, single clock) with registered read data and a built-in
//               init sequencer that writes INIT_VAL to every word after reset.
//               While the sweep runs, both ports are ignored.
//
// Parameters  : DATA_W   - word width in bits
//               ADDR_W   - address width in bits
//               DEPTH    - number of words (1 .. 2**ADDR_W)
//               INIT_VAL - value written to every word by the init sweep
//
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous reset, active low
//               wr_en     - write request
//               wr_addr   - write address
//               wr_data   - write data
//               rd_en     - read request
//               rd_addr   - read address
//               rd_data   - registered read data (0 when rd_valid=0)
//               rd_valid  - one-cycle strobe following each accepted read
//               init_busy - init sweep in progress
//               wr_err    - one-cycle pulse: write rejected (busy/out of range)
//
// Macro       : RAM_WR_BYPASS_EN - defined: write-first on a same-address
//               same-cycle read; undefined: read-first (old data).
//
// Revision    : 1.0 - initial release
// ============================================================================
module ram_2port_param #(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 7,
    parameter int                DEPTH    = 128,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_busy,
    output logic              wr_err
);

`ifdef RAM_WR_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_ptr;
    logic [ADDR_W-1:0]   w_init_ptr_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_wr_err;

    logic                w_busy;
    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_rd_word;

    // ------------------------------------------------------------------
    // Init sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        case (r_state)
            ST_INIT: begin
                // Leave INIT on the edge that clears the last word; the
                // pointer is held there rather than wrapping.
                if (r_init_ptr == c_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_init_ptr_nxt = r_init_ptr + 1'b1;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_busy        = (r_state == ST_INIT);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH_EXT);
    assign w_wr_ok       = wr_en && !w_busy && w_wr_in_range;

    // ------------------------------------------------------------------
    // Storage array: no reset, the init sweep owns the write port in INIT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_init_ptr] <= INIT_VAL;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Same-address collision: write-first forwards the incoming data,
    // read-first returns the array content before this edge.
    assign w_rd_word = (c_BYPASS && w_wr_ok && (wr_addr == rd_addr))
                       ? wr_data : r_mem[rd_addr];

    // ------------------------------------------------------------------
    // Registered read port and write-error strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            // Data is zeroed whenever no valid in-range read completes, so
            // nothing stale is ever presented.
            r_rd_data  <= (!w_busy && rd_en && w_rd_in_range) ? w_rd_word : '0;
            r_rd_valid <= !w_busy && rd_en;
            r_wr_err   <= wr_en && (w_busy || !w_wr_in_range);
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign wr_err    = r_wr_err;
    assign init_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_2port_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_2port_param
// Description : Self-checking bench for ram_2port_param. A reference model
//               pushes the expected read/error response when stimulus is
//               driven; the response is popped and compared after the edge.
//               A second instance (DEPTH=100, INIT_VAL=5) covers the
//               out-of-range address handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_2port_param;

    localparam int c_DW    = 4;
    localparam int c_AW    = 7;
    localparam int c_DEPTH = 128;

`ifdef RAM_WR_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    typedef struct packed {
        logic            v;
        logic [c_DW-1:0] d;
        logic            e;
    } resp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;

    logic            wr_en = 1'b0;
    logic [c_AW-1:0] wr_addr = '0;
    logic [c_DW-1:0] wr_data = '0;
    logic            rd_en = 1'b0;
    logic [c_AW-1:0] rd_addr = '0;
    logic [c_DW-1:0] rd_data;
    logic            rd_valid;
    logic            init_busy;
    logic            wr_err;

    logic            b_wr_en = 1'b0;
    logic [c_AW-1:0] b_wr_addr = '0;
    logic [c_DW-1:0] b_wr_data = '0;
    logic            b_rd_en = 1'b0;
    logic [c_AW-1:0] b_rd_addr = '0;
    logic [c_DW-1:0] b_rd_data;
    logic            b_rd_valid;
    logic            b_init_busy;
    logic            b_wr_err;

    int              n_checks = 0;
    int              n_errors = 0;

    logic [c_DW-1:0] m_mem [c_DEPTH];
    int              m_init_left = 0;
    resp_t           sb_q [$];

    always #5 clk = ~clk;

    ram_2port_param #(
        .DATA_W(c_DW), .ADDR_W(c_AW), .DEPTH(c_DEPTH), .INIT_VAL(4'h0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .init_busy(init_busy), .wr_err(wr_err)
    );

    ram_2port_param #(
        .DATA_W(c_DW), .ADDR_W(c_AW), .DEPTH(100), .INIT_VAL(4'h5)
    ) u_dut_d100 (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .init_busy(b_init_busy), .wr_err(b_wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus on the main instance: check busy, push the
    // model's expected response, clock, update the model, pop and compare.
    task automatic cyc(input logic we, input logic [c_AW-1:0] wa, input logic [c_DW-1:0] wd,
                       input logic re, input logic [c_AW-1:0] ra);
        resp_t exp_r;
        resp_t got;
        bit    busy;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        busy  = (m_init_left > 0);
        chk("init_busy", {31'd0, init_busy}, {31'd0, busy});
        exp_r.v = re && !busy;
        exp_r.d = '0;
        if (re && !busy && int'(ra) < c_DEPTH)
            exp_r.d = (c_BYP && we && wa == ra) ? wd : m_mem[ra];
        exp_r.e = we && (busy || int'(wa) >= c_DEPTH);
        sb_q.push_back(exp_r);
        @(posedge clk);
        if (busy) begin
            m_mem[c_DEPTH - m_init_left] = 4'h0;
            m_init_left--;
        end else if (we && int'(wa) < c_DEPTH) begin
            m_mem[wa] = wd;
        end
        #1;
        got   = sb_q.pop_front();
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, got.v});
        chk("rd_data",  {28'd0, rd_data},  {28'd0, got.d});
        chk("wr_err",   {31'd0, wr_err},   {31'd0, got.e});
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    // One clock on the DEPTH=100 instance with direct expected values.
    task automatic cyc_b(input logic we, input logic [c_AW-1:0] wa, input logic [c_DW-1:0] wd,
                         input logic re, input logic [c_AW-1:0] ra,
                         input logic exp_v, input logic [c_DW-1:0] exp_d, input logic exp_e);
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
        b_rd_en = re; b_rd_addr = ra;
        @(posedge clk);
        #1;
        chk("b_rd_valid", {31'd0, b_rd_valid}, {31'd0, exp_v});
        chk("b_rd_data",  {28'd0, b_rd_data},  {28'd0, exp_d});
        chk("b_wr_err",   {31'd0, b_wr_err},   {31'd0, exp_e});
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  {31'd0, init_busy}, 32'd1);
        chk({tag, "_valid"}, {31'd0, rd_valid},  32'd0);
        chk({tag, "_data"},  {28'd0, rd_data},   32'd0);
        chk({tag, "_err"},   {31'd0, wr_err},    32'd0);
    endtask

    initial begin
        // Reset state, then release between edges.
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b1;
        m_init_left = c_DEPTH;

        // Init sweep with reads and a write attempt mixed in: all ignored.
        cyc(1'b1, 7'd3, 4'hF, 1'b1, 7'd3);
        for (int i = 1; i < c_DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, 7'(i));

        // Every address reads back the init value.
        for (int a = 0; a < c_DEPTH; a++) cyc(1'b0, '0, '0, 1'b1, 7'(a));
        idle();

        // Write then read next cycle; then rd_en low gives zeros.
        cyc(1'b1, 7'd5, 4'hA, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 7'd5);
        idle();

        // Same-cycle same-address write/read, then read back new data.
        cyc(1'b1, 7'd9, 4'h3, 1'b1, 7'd9);
        cyc(1'b0, '0, '0, 1'b1, 7'd9);
        // Different addresses in the same cycle.
        cyc(1'b1, 7'd10, 4'h7, 1'b1, 7'd5);

        // Out-of-range handling on the DEPTH=100 instance (already initialised).
        chk("b_busy", {31'd0, b_init_busy}, 32'd0);
        cyc_b(1'b1, 7'd120, 4'hB, 1'b0, '0,     1'b0, 4'h0, 1'b1);
        cyc_b(1'b0, '0,     4'h0, 1'b1, 7'd120, 1'b1, 4'h0, 1'b0);
        cyc_b(1'b0, '0,     4'h0, 1'b1, 7'd99,  1'b1, 4'h5, 1'b0);
        cyc_b(1'b1, 7'd99,  4'hC, 1'b0, '0,     1'b0, 4'h0, 1'b0);
        cyc_b(1'b0, '0,     4'h0, 1'b1, 7'd99,  1'b1, 4'hC, 1'b0);
        cyc_b(1'b0, '0,     4'h0, 1'b0, '0,     1'b0, 4'h0, 1'b0);

        // Mid-run reset: writes during INIT are rejected, prior data cleared.
        cyc(1'b1, 7'd20, 4'h9, 1'b1, 7'd20);
        rst = 1'b0;
        #1;
        check_reset_state("rst2");
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_init_left = c_DEPTH;
        for (int i = 0; i < c_DEPTH; i++) cyc(1'b1, 7'(i), 4'h6, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 7'd5);
        cyc(1'b0, '0, '0, 1'b1, 7'd20);
        cyc(1'b0, '0, '0, 1'b1, 7'd0);

        // Random stream with a narrow address window to force collisions.
        for (int n = 0; n < 10000; n++) begin
            logic [c_AW-1:0] wa;
            logic [c_AW-1:0] ra;
            if (n[0]) begin
                wa = 7'($urandom_range(0, 15));
                ra = 7'($urandom_range(0, 15));
            end else begin
                wa = 7'($urandom_range(0, c_DEPTH - 1));
                ra = 7'($urandom_range(0, c_DEPTH - 1));
            end
            cyc(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ra);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
